ascon_instr_dec: RTL and testbench
==================================

# ascon_instr_dec

Upstream front-end of `ascon_core`. It consumes a single 32-bit instruction/data word stream of INS and DAT words and drives the core's `key*` and `bdi*` handshakes. It also drives the persistent `decrypt`/`hash` mode flags. It turns a host/DMA word stream into core transactions, replacing bench-side command parsing in system builds.

## Interface
- `CCW`, default 32 (package), bdi width; elaboration error if not 32.
- `CCSW`, default 32 (package), key width; elaboration error if not 32.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  32  INS word: op[31:28], flags[27:24] (flags[0]=eoi), len[23:0] bytes. Otherwise a DAT word.
- `in_valid` / `in_ready`  in/out  1  stream handshake; a word transfers when both are high.
- `key`  out  CCSW  key word.
- `key_valid` / `key_ready`  out/in  1  key handshake.
- `bdi`  out  CCW  block data.
- `bdi_valid` / `bdi_ready`  out/in  1  bdi handshake.
- `bdi_type`  out  4  D_NONCE/D_AD/D_PTCT/D_TAG; D_NULL when idle.
- `bdi_eot`  out  1  last word of segment.
- `bdi_eoi`  out  1  last segment of input (flags[0] on last word).
- `decrypt`, `hash`  out  1  mode flags to core.
- `busy`  out  1  a load is in progress.
- `err`  out  1  sticky; set by an unknown op; cleared only by `rst`.

## Operation
- FSM states: IDLE, LD_KEY, LD_BDI.
- IDLE: `in_ready`=1. Each accepted word is decoded as INS.
  - OP_DO_ENC: decrypt=0, hash=0.
  - OP_DO_DEC: decrypt=1, hash=0.
  - OP_DO_HASH: decrypt=0, hash=1.
  - DO ops are single-word; the FSM stays in IDLE.
  - OP_LD_KEY: go to LD_KEY.
  - OP_LD_NONCE/AD/PT/CT/TAG: go to LD_BDI; latch the type (PT and CT both map to D_PTCT) and latch flags[0].
  - Any other op: set err; the word is dropped.
- Word count: cnt = (len+3)>>2, computed in 25-bit arithmetic and held in a 23-bit register (max 2^22).
  - len=0 on a load op: consumed, no transfer issued, stays in IDLE.
- LD_KEY / LD_BDI are pure pass-through:
  - key/bdi = in_data.
  - key_valid or bdi_valid = in_valid.
  - in_ready = key_ready or bdi_ready.
- Each handshake decrements cnt.
  - While cnt==1, bdi_eot=1 and bdi_eoi = latched flags[0].
  - Key words never assert eot/eoi.
  - The final handshake returns the FSM to IDLE on the next edge.
- `busy` = state != IDLE.

## Timing
- Reset values:
  - state IDLE; cnt 0.
  - key_valid 0, bdi_valid 0, bdi_type D_NULL, bdi_eot 0, bdi_eoi 0.
  - decrypt 0, hash 0, busy 0, err 0; key/bdi 0.
  - in_ready is 1 from the first post-reset cycle.
- INS accepted at edge N: mode flags update at N+1, and the first DAT word may transfer in cycle N+1 (zero bubble).
- Last DAT handshake at edge M: IDLE at M+1, where the next INS may be accepted.
- Without the macro, the data path has zero-cycle latency and in_ready depends combinationally on key_ready/bdi_ready.
- A DAT word is held (no transfer) while the core is not ready. Outputs stay stable while valid is high and ready is low.
- rst mid-load: return to IDLE next edge; the remaining DAT words of the segment are not consumed specially. The upstream source must be reset with the block.
- `err` does not stall decoding.

## Configuration
- `ASCON_INSTR_SKID_EN` defined:
  - A 2-entry skid buffer is inserted between the in_* stream and the decoder.
  - in_ready becomes registered, with no combinational path from key_ready/bdi_ready.
  - +1 cycle latency from in_valid to key_valid/bdi_valid.
  - Full throughput is kept.
  - in_ready=0 only when both entries are full.
- Undefined: direct pass-through as above.

## Structure
- Shared package `ascon_pkg`: OP_* and D_* constants, CCW/CCSW.
- This block adds no new constants beyond a local state enum.
- One sub-module, `ascon_skid_buf` (parameter W; valid/ready both sides), instantiated only under the macro.

## Test plan
- After reset, send INS LD_KEY len=16 then 4 DAT words 0x00010203..0x0C0D0E0F with key_ready=1. Expect 4 consecutive key_valid cycles with matching key values, eot never set, busy low after the 4th handshake.
- Send INS LD_AD flags=0 len=5, then 2 DAT words, with bdi_ready toggling 1,0,1. Expect bdi_type=D_AD, held values during stalls, bdi_eot=1 only on the 2nd word, bdi_eoi=0.
- Send INS LD_PT flags=1 len=4, one DAT word. Expect bdi_type=D_PTCT, eot=1 and eoi=1 on that word, IDLE on the next cycle.
- Send DO_DEC then DO_HASH back to back. Expect decrypt=1/hash=0 one cycle after the first, then 0/1. An LD_AD with len=0 produces no bdi_valid.
- Send INS with an unused op value (e.g. 0xF0000000). Expect err=1 persisting; the next valid INS still decodes. Assert rst mid-segment: all outputs return to reset values on the next edge.
- Repeat the tests above with `ASCON_INSTR_SKID_EN`. Expect identical transfer sequences shifted by exactly 1 cycle and no throughput loss with ready held high.

Source files
------------

// File: rtl/ascon_pkg.sv
// ascon_pkg: shared ascon_core constants -- bus widths, instruction opcodes and bdi segment types.
package ascon_pkg;

  localparam int CCW  = 32;
  localparam int CCSW = 32;

  localparam logic [3:0] OP_LD_KEY   = 4'h1;
  localparam logic [3:0] OP_LD_NONCE = 4'h2;
  localparam logic [3:0] OP_LD_AD    = 4'h3;
  localparam logic [3:0] OP_LD_PT    = 4'h4;
  localparam logic [3:0] OP_LD_CT    = 4'h5;
  localparam logic [3:0] OP_LD_TAG   = 4'h6;
  localparam logic [3:0] OP_DO_ENC   = 4'h8;
  localparam logic [3:0] OP_DO_DEC   = 4'h9;
  localparam logic [3:0] OP_DO_HASH  = 4'hA;

  localparam logic [3:0] D_NULL  = 4'h0;
  localparam logic [3:0] D_NONCE = 4'h1;
  localparam logic [3:0] D_AD    = 4'h2;
  localparam logic [3:0] D_PTCT  = 4'h3;
  localparam logic [3:0] D_TAG   = 4'h4;

endpackage

// File: rtl/ascon_skid_buf.sv
// ascon_skid_buf: 2-entry skid buffer; s_ready_o is decoded from registered occupancy only,
// so nothing downstream reaches the upstream ready combinationally.
module ascon_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic [W-1:0] m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         push;
  logic         pop;

  assign s_ready_o = (cnt_q != 2'd2);
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = mem_q[rd_q];
  assign push      = s_valid_i && s_ready_o;
  assign pop       = m_valid_o && m_ready_i;

  // With both sides ready the occupancy sits at one entry, so throughput is one word per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= s_data_i;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ascon_instr_dec.sv
// ascon_instr_dec: decodes an INS/DAT word stream into ascon_core key/bdi transfers and mode flags.
// Define ASCON_INSTR_SKID_EN to place a 2-entry skid buffer in front of the decoder (registered in_ready).
module ascon_instr_dec #(
  parameter int CCW  = ascon_pkg::CCW,
  parameter int CCSW = ascon_pkg::CCSW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [CCSW-1:0] key,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [CCW-1:0]  bdi,
  output logic            bdi_valid,
  input  logic            bdi_ready,
  output logic [3:0]      bdi_type,
  output logic            bdi_eot,
  output logic            bdi_eoi,
  output logic            decrypt,
  output logic            hash,
  output logic            busy,
  output logic            err
);
  import ascon_pkg::*;

  if (CCW != 32) begin : g_ccw_chk
    $error("ascon_instr_dec: CCW must be 32");
  end
  if (CCSW != 32) begin : g_ccsw_chk
    $error("ascon_instr_dec: CCSW must be 32");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LD_KEY = 2'd1, S_LD_BDI = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [22:0] cnt_q, cnt_d;
  logic [3:0]  type_q, type_d;
  logic        eoi_q, eoi_d;
  logic        decrypt_q, decrypt_d;
  logic        hash_q, hash_d;
  logic        err_q, err_d;
  logic [31:0] dec_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [22:0] ins_words;

  // len of 2^24-1 rounds up to 2^22 words, hence the 25-bit sum.
  function automatic logic [22:0] word_count(input logic [23:0] len);
    logic [24:0] sum;
    sum = {1'b0, len} + 25'd3;
    return sum[24:2];
  endfunction

  function automatic logic [3:0] seg_type(input logic [3:0] op);
    case (op)
      OP_LD_NONCE:        return D_NONCE;
      OP_LD_AD:           return D_AD;
      OP_LD_PT, OP_LD_CT: return D_PTCT;
      OP_LD_TAG:          return D_TAG;
      default:            return D_NULL;
    endcase
  endfunction

`ifdef ASCON_INSTR_SKID_EN
  ascon_skid_buf #(.W(32)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (in_data),
    .s_valid_i (in_valid),
    .s_ready_o (in_ready),
    .m_data_o  (dec_data),
    .m_valid_o (dec_valid),
    .m_ready_i (dec_ready)
  );
`else
  assign dec_data  = in_data;
  assign dec_valid = in_valid;
  assign in_ready  = dec_ready;
`endif

  // Decode in IDLE; in the load states the DAT stream passes straight through to key or bdi.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    type_d    = type_q;
    eoi_d     = eoi_q;
    decrypt_d = decrypt_q;
    hash_d    = hash_q;
    err_d     = err_q;
    dec_ready = 1'b0;
    key       = '0;
    key_valid = 1'b0;
    bdi       = '0;
    bdi_valid = 1'b0;
    bdi_type  = D_NULL;
    bdi_eot   = 1'b0;
    bdi_eoi   = 1'b0;
    ins_words = word_count(dec_data[23:0]);
    case (state_q)
      S_IDLE: begin
        dec_ready = 1'b1;
        if (dec_valid) begin
          case (dec_data[31:28])
            OP_DO_ENC: begin
              decrypt_d = 1'b0;
              hash_d    = 1'b0;
            end
            OP_DO_DEC: begin
              decrypt_d = 1'b1;
              hash_d    = 1'b0;
            end
            OP_DO_HASH: begin
              decrypt_d = 1'b0;
              hash_d    = 1'b1;
            end
            OP_LD_KEY: begin
              cnt_d   = ins_words;
              state_d = (ins_words != 23'd0) ? S_LD_KEY : S_IDLE;
            end
            OP_LD_NONCE, OP_LD_AD, OP_LD_PT, OP_LD_CT, OP_LD_TAG: begin
              cnt_d   = ins_words;
              type_d  = seg_type(dec_data[31:28]);
              eoi_d   = dec_data[24];
              state_d = (ins_words != 23'd0) ? S_LD_BDI : S_IDLE;
            end
            default: err_d = 1'b1;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LD_KEY: begin
        key       = dec_data;
        key_valid = dec_valid;
        dec_ready = key_ready;
        if (dec_valid && key_ready) begin
          cnt_d   = cnt_q - 23'd1;
          state_d = (cnt_q == 23'd1) ? S_IDLE : S_LD_KEY;
        end else begin
          state_d = S_LD_KEY;
        end
      end
      S_LD_BDI: begin
        bdi       = dec_data;
        bdi_valid = dec_valid;
        dec_ready = bdi_ready;
        bdi_type  = type_q;
        bdi_eot   = (cnt_q == 23'd1);
        bdi_eoi   = (cnt_q == 23'd1) && eoi_q;
        if (dec_valid && bdi_ready) begin
          cnt_d   = cnt_q - 23'd1;
          state_d = (cnt_q == 23'd1) ? S_IDLE : S_LD_BDI;
        end else begin
          state_d = S_LD_BDI;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoder state and persistent flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 23'd0;
      type_q    <= D_NULL;
      eoi_q     <= 1'b0;
      decrypt_q <= 1'b0;
      hash_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      type_q    <= type_d;
      eoi_q     <= eoi_d;
      decrypt_q <= decrypt_d;
      hash_q    <= hash_d;
      err_q     <= err_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign decrypt = decrypt_q;
  assign hash    = hash_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ascon_instr_dec.sv
// tb_ascon_instr_dec: table-driven, directed and randomized checks of ascon_instr_dec against a
// transaction-level model. Builds with or without ASCON_INSTR_SKID_EN (adds one cycle of latency).
`timescale 1ns/1ps
module tb_ascon_instr_dec;
  import ascon_pkg::*;

`ifdef ASCON_INSTR_SKID_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] key;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] bdi;
  logic        bdi_valid;
  logic        bdi_ready;
  logic [3:0]  bdi_type;
  logic        bdi_eot;
  logic        bdi_eoi;
  logic        decrypt;
  logic        hash;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  ascon_instr_dec dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .key_valid(key_valid), .key_ready(key_ready),
    .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready), .bdi_type(bdi_type),
    .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi), .decrypt(decrypt), .hash(hash), .busy(busy), .err(err)
  );

  typedef struct {
    logic        is_key;
    logic [31:0] data;
    logic [3:0]  typ;
    logic        eot;
    logic        eoi;
  } xfer_t;

  typedef struct {
    logic [31:0] ins;
    int          n;
    logic        is_key;
    logic [3:0]  typ;
    logic        dec;
    logic        hsh;
    logic        er;
  } vec_t;

  xfer_t       exp_q[$];
  logic [31:0] words_q[$];
  int          hs_cyc[$];
  logic        busy_h[$];
  logic        dec_h[$];
  logic        hash_h[$];
  bit          rdy_pat[$];
  int          nvalid;
  int          nstall;
  int          nbusy;
  bit          rnd_mode;
  logic        mdl_dec, mdl_hash, mdl_err;
  int          n_checks = 0;
  int          n_fail = 0;
  vec_t        tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] mk_ins(input logic [3:0] op, input logic [3:0] fl, input logic [23:0] len);
    return {op, fl, len};
  endfunction

  task automatic add_dat(input logic k, input logic [3:0] t, input bit last, input logic eoi_flag,
                         input logic [31:0] data);
    xfer_t x;
    words_q.push_back(data);
    x.is_key = k;
    x.data   = data;
    x.typ    = t;
    x.eot    = last && !k;
    x.eoi    = last && !k && eoi_flag;
    exp_q.push_back(x);
  endtask

  // Reference model: ceil(len/4) data words per load, mode flags and sticky error from the opcode.
  task automatic model_ins(input logic [3:0] op, input logic [3:0] fl, input logic [23:0] len);
    int n;
    logic k, ld;
    logic [3:0] t;
    words_q.push_back(mk_ins(op, fl, len));
    n = (int'(len) + 3) / 4;
    ld = 1'b1;
    k = 1'b0;
    t = D_NULL;
    case (op)
      OP_DO_ENC:          begin mdl_dec = 1'b0; mdl_hash = 1'b0; ld = 1'b0; end
      OP_DO_DEC:          begin mdl_dec = 1'b1; mdl_hash = 1'b0; ld = 1'b0; end
      OP_DO_HASH:         begin mdl_dec = 1'b0; mdl_hash = 1'b1; ld = 1'b0; end
      OP_LD_KEY:          k = 1'b1;
      OP_LD_NONCE:        t = D_NONCE;
      OP_LD_AD:           t = D_AD;
      OP_LD_PT, OP_LD_CT: t = D_PTCT;
      OP_LD_TAG:          t = D_TAG;
      default:            begin mdl_err = 1'b1; ld = 1'b0; end
    endcase
    if (ld) begin
      for (int i = 0; i < n; i++) add_dat(k, t, i == n - 1, fl[0], $urandom);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_key_valid"}, key_valid, 1'b0);
    chk({tag, "_bdi_valid"}, bdi_valid, 1'b0);
    chk({tag, "_bdi_type"}, bdi_type, D_NULL);
    chk({tag, "_eot_eoi"}, {bdi_eot, bdi_eoi}, 2'b00);
    chk({tag, "_mode"}, {decrypt, hash}, 2'b00);
    chk({tag, "_key_bdi"}, {key, bdi}, 64'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_dec = 1'b0;
    mdl_hash = 1'b0;
    mdl_err = 1'b0;
  endtask

  // Streams words_q back to back, monitors every handshake against exp_q; step index = edge index.
  task automatic run(input int extra);
    int cyc, budget, idle, ri;
    logic rdy, accepted, st_key, st_bdi;
    logic [31:0] st_key_d;
    logic [37:0] st_bdi_d;
    xfer_t e;
    hs_cyc.delete(); busy_h.delete(); dec_h.delete(); hash_h.delete();
    nvalid = 0; nstall = 0; nbusy = 0; idle = 0; cyc = 0;
    st_key = 1'b0; st_bdi = 1'b0; st_key_d = '0; st_bdi_d = '0;
    budget = 200 + 20 * words_q.size();
    while (cyc < budget && idle <= extra) begin
      if (!in_valid && words_q.size() > 0 && (!rnd_mode || $urandom_range(3) != 0)) begin
        in_data = words_q.pop_front();
        in_valid = 1'b1;
      end
      ri = cyc - LAT - 1;
      rdy = (ri >= 0 && ri < rdy_pat.size()) ? rdy_pat[ri] : 1'b1;
      key_ready = rnd_mode ? ($urandom_range(2) != 0) : rdy;
      bdi_ready = rnd_mode ? ($urandom_range(2) != 0) : rdy;
      @(negedge clk);
      busy_h.push_back(busy); dec_h.push_back(decrypt); hash_h.push_back(hash);
      if (busy) nbusy++;
      if (bdi_valid) nvalid++;
      if (bdi_valid && !bdi_ready) nstall++;
      if (st_key) begin
        chk("key_hold_valid", key_valid, 1'b1);
        chk("key_hold_data", key, st_key_d);
      end
      if (st_bdi) begin
        chk("bdi_hold_valid", bdi_valid, 1'b1);
        chk("bdi_hold_fields", {bdi, bdi_type, bdi_eot, bdi_eoi}, st_bdi_d);
      end
      st_key = key_valid && !key_ready;
      st_key_d = key;
      st_bdi = bdi_valid && !bdi_ready;
      st_bdi_d = {bdi, bdi_type, bdi_eot, bdi_eoi};
      if ((key_valid && key_ready) || (bdi_valid && bdi_ready)) begin
        chk("spurious_xfer", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          hs_cyc.push_back(cyc);
          chk("xfer_kind", {key_valid, bdi_valid}, {e.is_key, !e.is_key});
          if (e.is_key) begin
            chk("key_data", key, e.data);
            chk("key_no_eot", {bdi_eot, bdi_eoi}, 2'b00);
          end else begin
            chk("bdi_data", bdi, e.data);
            chk("bdi_type", bdi_type, e.typ);
            chk("bdi_eot", bdi_eot, e.eot);
            chk("bdi_eoi", bdi_eoi, e.eoi);
          end
        end
      end
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) in_valid = 1'b0;
      if (words_q.size() == 0 && !in_valid && exp_q.size() == 0) idle++;
      cyc++;
    end
    chk("run_drained_xfers", exp_q.size(), 0);
    chk("run_drained_words", words_q.size() + int'(in_valid), 0);
    exp_q.delete(); words_q.delete(); in_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{mk_ins(OP_LD_KEY,   4'h0, 24'd16), 4, 1'b1, D_NULL,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{mk_ins(OP_LD_NONCE, 4'h1, 24'd16), 4, 1'b0, D_NONCE, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{mk_ins(OP_LD_AD,    4'h0, 24'd5),  2, 1'b0, D_AD,    1'b0, 1'b0, 1'b0};
    tbl[3]  = '{mk_ins(OP_LD_PT,    4'h1, 24'd4),  1, 1'b0, D_PTCT,  1'b0, 1'b0, 1'b0};
    tbl[4]  = '{mk_ins(OP_LD_CT,    4'hE, 24'd3),  1, 1'b0, D_PTCT,  1'b0, 1'b0, 1'b0};
    tbl[5]  = '{mk_ins(OP_LD_TAG,   4'h1, 24'd1),  1, 1'b0, D_TAG,   1'b0, 1'b0, 1'b0};
    tbl[6]  = '{mk_ins(OP_LD_AD,    4'h1, 24'd0),  0, 1'b0, D_AD,    1'b0, 1'b0, 1'b0};
    tbl[7]  = '{mk_ins(OP_LD_KEY,   4'h0, 24'd0),  0, 1'b1, D_NULL,  1'b0, 1'b0, 1'b0};
    tbl[8]  = '{mk_ins(OP_DO_DEC,   4'h0, 24'd0),  0, 1'b0, D_NULL,  1'b1, 1'b0, 1'b0};
    tbl[9]  = '{mk_ins(OP_DO_HASH,  4'h0, 24'd7),  0, 1'b0, D_NULL,  1'b0, 1'b1, 1'b0};
    tbl[10] = '{mk_ins(OP_DO_ENC,   4'h0, 24'd0),  0, 1'b0, D_NULL,  1'b0, 1'b0, 1'b0};
    tbl[11] = '{32'hF0000000,                      0, 1'b0, D_NULL,  1'b0, 1'b0, 1'b1};
    tbl[12] = '{mk_ins(OP_LD_AD,    4'h0, 24'd8),  2, 1'b0, D_AD,    1'b0, 1'b0, 1'b1};
    tbl[13] = '{mk_ins(4'h0,        4'h0, 24'd4),  0, 1'b0, D_NULL,  1'b0, 1'b0, 1'b1};

    in_data = '0; in_valid = 1'b0; key_ready = 1'b1; bdi_ready = 1'b1; rnd_mode = 1'b0;
    do_reset();
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;

    // Decode table: each record gives the expected transfer count/type and the flags afterwards.
    for (int v = 0; v < 14; v++) begin
      words_q.push_back(tbl[v].ins);
      for (int i = 0; i < tbl[v].n; i++)
        add_dat(tbl[v].is_key, tbl[v].typ, i == tbl[v].n - 1, tbl[v].ins[24], $urandom);
      run(3);
      chk($sformatf("tbl%0d_count", v), hs_cyc.size(), tbl[v].n);
      chk($sformatf("tbl%0d_mode", v), {decrypt, hash}, {tbl[v].dec, tbl[v].hsh});
      chk($sformatf("tbl%0d_err", v), err, tbl[v].er);
    end

    do_reset();
    // Key load: four back-to-back key words, busy falls the cycle after the last.
    words_q.push_back(mk_ins(OP_LD_KEY, 4'h0, 24'd16));
    for (int i = 0; i < 4; i++) add_dat(1'b1, D_NULL, i == 3, 1'b0, 32'h00010203 + 32'h04040404 * i);
    run(4);
    chk("key_count", hs_cyc.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("key_cycle%0d", i), hs_cyc[i], 1 + LAT + i);
    chk("key_busy_last", busy_h[4 + LAT], 1'b1);
    chk("key_busy_after", busy_h[5 + LAT], 1'b0);

    // AD load with a single stall on the second word.
    rdy_pat = '{1'b1, 1'b0, 1'b1};
    model_ins(OP_LD_AD, 4'h0, 24'd5);
    run(4);
    rdy_pat.delete();
    chk("ad_count", hs_cyc.size(), 2);
    chk("ad_cycle0", hs_cyc[0], 1 + LAT);
    chk("ad_cycle1", hs_cyc[1], 3 + LAT);
    chk("ad_stalls", nstall, 1);

    // PT with eoi: single word, back to IDLE on the following cycle.
    model_ins(OP_LD_PT, 4'h1, 24'd4);
    run(4);
    chk("pt_cycle", hs_cyc[0], 1 + LAT);
    chk("pt_busy_during", busy_h[1 + LAT], 1'b1);
    chk("pt_busy_after", busy_h[2 + LAT], 1'b0);

    // DO_DEC then DO_HASH back to back.
    model_ins(OP_DO_DEC, 4'h0, 24'd0);
    model_ins(OP_DO_HASH, 4'h0, 24'd0);
    run(4);
    chk("do_dec_first", {dec_h[1 + LAT], hash_h[1 + LAT]}, 2'b10);
    chk("do_hash_second", {dec_h[2 + LAT], hash_h[2 + LAT]}, 2'b01);
    chk("do_mode_before", {dec_h[LAT], hash_h[LAT]}, 2'b00);

    model_ins(OP_LD_AD, 4'h1, 24'd0);
    run(4);
    chk("len0_no_valid", nvalid, 0);
    chk("len0_never_busy", nbusy, 0);

    // Unknown op sets sticky err; decoding continues.
    model_ins(4'hF, 4'h0, 24'd0);
    model_ins(OP_LD_NONCE, 4'h1, 24'd4);
    run(4);
    chk("err_sticky", err, 1'b1);
    chk("err_then_nonce", hs_cyc.size(), 1);

    // Randomized stream against the model.
    do_reset();
    rnd_mode = 1'b1;
    for (int k = 0; k < 80; k++)
      model_ins(4'($urandom_range(15)), 4'($urandom), 24'($urandom_range(21)));
    run(6);
    rnd_mode = 1'b0;
    chk("rnd_mode_flags", {decrypt, hash}, {mdl_dec, mdl_hash});
    chk("rnd_err", err, mdl_err);

    // Reset in the middle of a TAG segment.
    do_reset();
    words_q.push_back(mk_ins(OP_LD_TAG, 4'h1, 24'd16));
    add_dat(1'b0, D_TAG, 1'b0, 1'b1, 32'hA5A5_0001);
    add_dat(1'b0, D_TAG, 1'b0, 1'b1, 32'hA5A5_0002);
    run(3);
    chk("midseg_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset("midseg_rst");
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
